banked_regfile: RTL and testbench

//  Parametrised ARM-style register file: 16 logical GPRs plus FIQ/SVC/ABT/IRQ/UND shadow banks, CPSR and 5 SPSRs.
//  The physical bank is selected by CPSR[4:0].

---
 rtl/banked_regfile.sv | 193 +++++++++++++++++++
 tb/tb_banked_regfile.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/banked_regfile.sv
// banked_regfile: single-clock ARM-style banked register file.
//   16 logical GPRs (r15 = PC) with FIQ (r8-r14) and SVC/ABT/IRQ/UND (r13-r14)
//   shadow banks, CPSR, five SPSRs, a two-step exception-entry sequencer and
//   exception return. The bank is selected by CPSR[4:0].
// Ports:
//   clk1, rst                  clock, synchronous active-high reset
//   rd_addr/rd_data            NUM_RD combinational read ports (4-bit addr each)
//   pc_read                    current r15
//   wr_en/wr_addr/wr_data      GPR write
//   pc_we/pc_wdata             r15 write (wr_en to r15 takes precedence)
//   cpsr_we/wdata/mask, cpsr   masked CPSR write, current CPSR
//   spsr_we/wdata, spsr        SPSR of current mode (0 where none exists)
//   eret                       CPSR <= SPSR(current mode)
//   exc_req/mode/vec/ret       exception entry request
//   exc_busy, exc_ack          sequencer active, entry-complete pulse
// Optional feature: define REGBANK_BYPASS_EN for same-cycle write forwarding.
module banked_regfile #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       NUM_RD     = 2,
  parameter logic [DATA_W-1:0] RESET_PC   = '0,
  parameter logic [DATA_W-1:0] RESET_CPSR = DATA_W'(32'h000000D3)
) (
  input  logic                       clk1,
  input  logic                       rst,
  input  logic [NUM_RD*4-1:0]        rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]          pc_read,
  input  logic                       wr_en,
  input  logic [3:0]                 wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pc_we,
  input  logic [DATA_W-1:0]          pc_wdata,
  input  logic                       cpsr_we,
  input  logic [DATA_W-1:0]          cpsr_wdata,
  input  logic [DATA_W-1:0]          cpsr_mask,
  output logic [DATA_W-1:0]          cpsr,
  input  logic                       spsr_we,
  input  logic [DATA_W-1:0]          spsr_wdata,
  output logic [DATA_W-1:0]          spsr,
  input  logic                       eret,
  input  logic                       exc_req,
  input  logic [4:0]                 exc_mode,
  input  logic [DATA_W-1:0]          exc_vec,
  input  logic [DATA_W-1:0]          exc_ret,
  output logic                       exc_busy,
  output logic                       exc_ack
);

  typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_SWITCH} state_e;
  typedef enum logic [2:0] {BK_BASE, BK_FIQ, BK_SVC, BK_ABT, BK_IRQ, BK_UND} bank_e;

  // Flat physical storage: base r0-r14 at 0..14, FIQ r8-r14 at 15..21,
  // then r13/r14 pairs for SVC (22), ABT (24), IRQ (26), UND (28).
  localparam int unsigned NUM_PHYS = 30;

  logic [DATA_W-1:0] regs   [NUM_PHYS];
  logic [DATA_W-1:0] spsr_r [6];  // entry 0 (base bank) is never written
  logic [DATA_W-1:0] pc_r;
  logic [DATA_W-1:0] cpsr_r;
  logic [DATA_W-1:0] pc_fwd;

  state_e            state, state_next;
  logic [4:0]        tgt_mode;
  logic [DATA_W-1:0] tgt_vec;
  logic [DATA_W-1:0] tgt_ret;
  bank_e             cur_bank, tgt_bank;
  logic              wr_fire, pc_fire;

  function automatic bank_e mode_bank(input logic [4:0] m);
    case (m)
      5'b10001: mode_bank = BK_FIQ;
      5'b10011: mode_bank = BK_SVC;
      5'b10111: mode_bank = BK_ABT;
      5'b10010: mode_bank = BK_IRQ;
      5'b11011: mode_bank = BK_UND;
      default:  mode_bank = BK_BASE;
    endcase
  endfunction

  function automatic logic [4:0] phys_idx(input bank_e b, input logic [3:0] a);
    logic [4:0] ax;
    ax = {1'b0, a};
    phys_idx = ax;
    case (b)
      BK_FIQ: if (a >= 4'd8)  phys_idx = ax + 5'd7;
      BK_SVC: if (a >= 4'd13) phys_idx = ax + 5'd9;
      BK_ABT: if (a >= 4'd13) phys_idx = ax + 5'd11;
      BK_IRQ: if (a >= 4'd13) phys_idx = ax + 5'd13;
      BK_UND: if (a >= 4'd13) phys_idx = ax + 5'd15;
      default: ;
    endcase
    if (a == 4'hF) phys_idx = '0;  // r15 lives in pc_r, never indexes the array
  endfunction

  assign cur_bank = mode_bank(cpsr_r[4:0]);
  assign tgt_bank = mode_bank(tgt_mode);

  // Strobes only take effect in IDLE and are dropped when exc_req wins the cycle.
  assign wr_fire = (state == ST_IDLE) && !exc_req && wr_en;
  assign pc_fire = (state == ST_IDLE) && !exc_req && pc_we;

  assign exc_busy = (state != ST_IDLE);
  assign exc_ack  = (state == ST_SWITCH);
  assign cpsr     = cpsr_r;
  assign spsr     = (cur_bank == BK_BASE) ? '0 : spsr_r[cur_bank];
  assign pc_read  = pc_fwd;

  always_comb begin
    pc_fwd = pc_r;
`ifdef REGBANK_BYPASS_EN
    if (wr_fire && wr_addr == 4'hF) pc_fwd = wr_data;
    else if (pc_fire)               pc_fwd = pc_wdata;
`endif
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (rd_addr[4*k +: 4] == 4'hF)
        rd_data[k*DATA_W +: DATA_W] = pc_fwd;
      else
        rd_data[k*DATA_W +: DATA_W] = regs[phys_idx(cur_bank, rd_addr[4*k +: 4])];
`ifdef REGBANK_BYPASS_EN
      if (wr_fire && wr_addr != 4'hF && rd_addr[4*k +: 4] == wr_addr)
        rd_data[k*DATA_W +: DATA_W] = wr_data;
`endif
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (exc_req) state_next = ST_SAVE;
      ST_SAVE:   state_next = ST_SWITCH;
      ST_SWITCH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PHYS; i++) regs[i] <= '0;
      for (int unsigned i = 0; i < 6; i++) spsr_r[i] <= '0;
      pc_r     <= RESET_PC;
      cpsr_r   <= RESET_CPSR;
      tgt_mode <= '0;
      tgt_vec  <= '0;
      tgt_ret  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (exc_req) begin
            tgt_mode <= exc_mode;
            tgt_vec  <= exc_vec;
            tgt_ret  <= exc_ret;
          end else begin
            if (pc_we && !(wr_en && wr_addr == 4'hF)) pc_r <= pc_wdata;
            if (wr_en) begin
              if (wr_addr == 4'hF) pc_r <= wr_data;
              else                 regs[phys_idx(cur_bank, wr_addr)] <= wr_data;
            end
            if (eret) begin
              if (cur_bank != BK_BASE) cpsr_r <= spsr_r[cur_bank];
            end else if (cpsr_we) begin
              cpsr_r <= (cpsr_r & ~cpsr_mask) | (cpsr_wdata & cpsr_mask);
            end
            if (spsr_we && cur_bank != BK_BASE) spsr_r[cur_bank] <= spsr_wdata;
          end
        end
        ST_SAVE: begin
          if (tgt_bank != BK_BASE) begin
            spsr_r[tgt_bank]               <= cpsr_r;
            regs[phys_idx(tgt_bank, 4'd14)] <= tgt_ret;
          end
        end
        ST_SWITCH: begin
          cpsr_r[4:0] <= tgt_mode;
          cpsr_r[5]   <= 1'b0;
          cpsr_r[7]   <= 1'b1;
          if (tgt_bank == BK_FIQ) cpsr_r[6] <= 1'b1;
          pc_r <= tgt_vec;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_regfile.sv
// Directed-vector bench for banked_regfile (DATA_W=32, NUM_RD=2).
module tb_banked_regfile;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_RD = 2;
`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clk1 = 1'b0;
  logic                     rst;
  logic [NUM_RD*4-1:0]      rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [DATA_W-1:0]        pc_read;
  logic                     wr_en;
  logic [3:0]               wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     pc_we;
  logic [DATA_W-1:0]        pc_wdata;
  logic                     cpsr_we;
  logic [DATA_W-1:0]        cpsr_wdata;
  logic [DATA_W-1:0]        cpsr_mask;
  logic [DATA_W-1:0]        cpsr;
  logic                     spsr_we;
  logic [DATA_W-1:0]        spsr_wdata;
  logic [DATA_W-1:0]        spsr;
  logic                     eret;
  logic                     exc_req;
  logic [4:0]               exc_mode;
  logic [DATA_W-1:0]        exc_vec;
  logic [DATA_W-1:0]        exc_ret;
  logic                     exc_busy;
  logic                     exc_ack;

  int n_vec = 0;
  int n_err = 0;

  banked_regfile #(
    .DATA_W    (DATA_W),
    .NUM_RD    (NUM_RD),
    .RESET_PC  (32'h0000_0000),
    .RESET_CPSR(32'h0000_00D3)
  ) dut (
    .clk1      (clk1),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pc_read   (pc_read),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pc_we     (pc_we),
    .pc_wdata  (pc_wdata),
    .cpsr_we   (cpsr_we),
    .cpsr_wdata(cpsr_wdata),
    .cpsr_mask (cpsr_mask),
    .cpsr      (cpsr),
    .spsr_we   (spsr_we),
    .spsr_wdata(spsr_wdata),
    .spsr      (spsr),
    .eret      (eret),
    .exc_req   (exc_req),
    .exc_mode  (exc_mode),
    .exc_vec   (exc_vec),
    .exc_ret   (exc_ret),
    .exc_busy  (exc_busy),
    .exc_ack   (exc_ack)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic clear();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pc_we = 1'b0; pc_wdata = '0;
    cpsr_we = 1'b0; cpsr_wdata = '0; cpsr_mask = '0;
    spsr_we = 1'b0; spsr_wdata = '0;
    eret = 1'b0;
    exc_req = 1'b0; exc_mode = '0; exc_vec = '0; exc_ret = '0;
  endtask

  task automatic set_cpsr(input logic [31:0] mask, input logic [31:0] data);
    cpsr_we = 1'b1; cpsr_mask = mask; cpsr_wdata = data;
    step();
    clear();
  endtask

  task automatic write_gpr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    clear();
  endtask

  initial begin
    clear();
    rd_addr = 8'h10;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // reset state
    check("rst_pc", 64'(pc_read), 64'h0);
    check("rst_cpsr", 64'(cpsr), 64'hD3);
    check("rst_rd", 64'(rd_data), 64'h0);
    check("rst_spsr", 64'(spsr), 64'h0);
    check("rst_busy_ack", 64'({exc_busy, exc_ack}), 64'h0);

    // SVC r13 shadow vs USR base
    rd_addr = {4'd14, 4'd13};
    write_gpr(4'd13, 32'hAAAA);
    check("svc_r13", 64'(rd_data[31:0]), 64'hAAAA);
    set_cpsr(32'h1F, 32'h10);
    check("usr_cpsr", 64'(cpsr), 64'hD0);
    check("usr_r13", 64'(rd_data[31:0]), 64'h0);
    set_cpsr(32'h1F, 32'h13);
    check("svc_r13_back", 64'(rd_data[31:0]), 64'hAAAA);
    spsr_we = 1'b1; spsr_wdata = 32'h55;
    step(); clear();
    check("svc_spsr", 64'(spsr), 64'h55);

    // FIQ r8 shadow; write uses the pre-edge mode
    set_cpsr(32'h1F, 32'h11);
    check("fiq_cpsr", 64'(cpsr), 64'hD1);
    check("fiq_spsr0", 64'(spsr), 64'h0);
    rd_addr = {4'd8, 4'd13};
    check("fiq_r13", 64'(rd_data[31:0]), 64'h0);
    write_gpr(4'd8, 32'h1234);
    check("fiq_r8", 64'(rd_data[63:32]), 64'h1234);
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 32'hBEEF;
    set_cpsr(32'h1F, 32'h10);
    check("usr_r8_base", 64'(rd_data[63:32]), 64'h0);
    rd_addr = {4'd8, 4'd7};
    write_gpr(4'd7, 32'h77);
    check("usr_r7", 64'(rd_data[31:0]), 64'h77);
    set_cpsr(32'h1F, 32'h11);
    check("fiq_r7_shared", 64'(rd_data[31:0]), 64'h77);
    check("fiq_r8_samecyc", 64'(rd_data[63:32]), 64'hBEEF);

    // exception entry into FIQ from USR
    set_cpsr(32'hFFFF_FFFF, 32'h10);
    check("pre_exc_cpsr", 64'(cpsr), 64'h10);
    rd_addr = {4'd14, 4'd1};
    exc_req = 1'b1; exc_mode = 5'b10001; exc_ret = 32'h104; exc_vec = 32'h1C;
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h99;
    cpsr_we = 1'b1; cpsr_mask = 32'hFF; cpsr_wdata = 32'h1F;
    step(); clear();
    check("save_busy_ack", 64'({exc_busy, exc_ack}), 64'h2);
    check("save_cpsr", 64'(cpsr), 64'h10);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hDEAD;
    pc_we = 1'b1; pc_wdata = 32'h500;
    exc_req = 1'b1; exc_mode = 5'b10011;
    step(); clear();
    check("switch_busy_ack", 64'({exc_busy, exc_ack}), 64'h3);
    step();
    check("done_busy_ack", 64'({exc_busy, exc_ack}), 64'h0);
    check("exc_cpsr", 64'(cpsr), 64'hD1);
    check("exc_spsr", 64'(spsr), 64'h10);
    check("exc_lr", 64'(rd_data[63:32]), 64'h104);
    check("exc_r1_dropped", 64'(rd_data[31:0]), 64'h0);
    check("exc_pc", 64'(pc_read), 64'h1C);

    // exception return
    eret = 1'b1; step(); clear();
    check("eret_fiq", 64'(cpsr), 64'h10);
    check("eret_usr_spsr", 64'(spsr), 64'h0);
    eret = 1'b1; step(); clear();
    check("eret_usr_noop", 64'(cpsr), 64'h10);
    set_cpsr(32'hFF, 32'h92);
    check("irq_cpsr", 64'(cpsr), 64'h92);
    spsr_we = 1'b1; spsr_wdata = 32'h13;
    step(); clear();
    check("irq_spsr", 64'(spsr), 64'h13);
    eret = 1'b1;
    set_cpsr(32'hFFFF_FFFF, 32'hFF);
    check("eret_beats_cpsr_we", 64'(cpsr), 64'h13);
    check("svc_spsr_kept", 64'(spsr), 64'h55);

    // r15 write conflict and forwarding
    rd_addr = {4'd15, 4'd3};
    wr_en = 1'b1; wr_addr = 4'hF; wr_data = 32'h200;
    pc_we = 1'b1; pc_wdata = 32'h204;
    step(); clear();
    check("pc_conflict", 64'(pc_read), 64'h200);
    check("rd_r15", 64'(rd_data[63:32]), 64'h200);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h3333;
    pc_we = 1'b1; pc_wdata = 32'h300;
    #1;
    check("bypass_rd", 64'(rd_data[31:0]), BYP ? 64'h3333 : 64'h0);
    check("bypass_pc", 64'(pc_read), BYP ? 64'h300 : 64'h200);
    step(); clear();
    check("post_wr_rd", 64'(rd_data[31:0]), 64'h3333);
    check("post_wr_pc", 64'(pc_read), 64'h300);

    // invalid target mode: only CPSR/PC change
    rd_addr = {4'd14, 4'd13};
    exc_req = 1'b1; exc_mode = 5'b00000; exc_vec = 32'h40; exc_ret = 32'h50;
    step(); clear();
    step(); step();
    check("inv_cpsr", 64'(cpsr), 64'h80);
    check("inv_pc", 64'(pc_read), 64'h40);
    check("inv_base_lr", 64'(rd_data[63:32]), 64'h0);
    check("inv_spsr", 64'(spsr), 64'h0);

    // reset in the middle of an entry sequence
    exc_req = 1'b1; exc_mode = 5'b10011; exc_vec = 32'h8; exc_ret = 32'h60;
    step(); clear();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy_ack", 64'({exc_busy, exc_ack}), 64'h0);
    check("mid_rst_cpsr", 64'(cpsr), 64'hD3);
    check("mid_rst_pc", 64'(pc_read), 64'h0);
    check("mid_rst_spsr", 64'(spsr), 64'h0);
    check("mid_rst_svc_regs", 64'(rd_data), 64'h0);
    step();
    check("mid_rst_stays_idle", 64'({exc_busy, exc_ack}), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
